// File: rtl/param_def.sv
// Shared datapath width definitions for the result path.
`ifndef PARAM_DEF_SV
`define PARAM_DEF_SV
`define MAC_BW 8
`endif

// File: rtl/result_merge.sv
`include "param_def.sv"
`default_nettype none
// ============================================================================
//  Module      : result_merge
//  Description : Reorders MAC / NL results back into issue order via a tag FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_merge #(
  parameter int LANES = 64,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  input  logic [1:0]                issue_mode,
  output logic                      issue_ready,
  input  logic                      mac_valid,
  input  logic [`MAC_BW*LANES-1:0]  mac_res,
  output logic                      mac_ready,
  input  logic                      nl_valid,
  input  logic [`MAC_BW*LANES-1:0]  nl_res,
  output logic                      nl_ready,
  output logic [`MAC_BW*LANES-1:0]  oC,
  output logic [1:0]                o_mode,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic                      stray_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = `MAC_BW * LANES;
  localparam logic [AW:0] C_ONE = 1;

  logic [1:0]    tag_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   mac_cnt_q, mac_cnt_d;
  logic [AW:0]   nl_cnt_q, nl_cnt_d;
  logic          mac_hv_q, nl_hv_q;
  logic [DW-1:0] mac_hd_q, nl_hd_q;
  logic          stray_q;

  logic          w_empty, w_full, w_push, w_pop;
  logic [1:0]    w_head_tag;
  logic          w_head_nl;
  logic          w_mac_fire, w_nl_fire;
  logic          w_mac_cap, w_nl_cap;
  logic          w_mac_stray, w_nl_stray;
  logic          w_mac_inc, w_mac_dec, w_nl_inc, w_nl_dec;

  // Extra pointer bit tells full (MSBs differ) from empty (all equal).
  assign w_empty    = (wr_ptr_q == rd_ptr_q);
  assign w_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_head_tag = tag_q[rd_ptr_q[AW-1:0]];
  assign w_head_nl  = (w_head_tag != 2'd0);

  assign issue_ready = !w_full;
  assign w_push      = issue_valid && issue_ready;

  assign o_valid = !w_empty && (w_head_nl ? nl_hv_q : mac_hv_q);
  assign w_pop   = o_valid && o_ready;
  assign oC      = o_valid ? (w_head_nl ? nl_hd_q : mac_hd_q) : '0;
  assign o_mode  = o_valid ? w_head_tag : 2'd0;

  // A hold register frees up in the same cycle its content is popped.
  assign mac_ready = !mac_hv_q || (w_pop && !w_head_nl);
  assign nl_ready  = !nl_hv_q  || (w_pop &&  w_head_nl);

  assign w_mac_fire  = mac_valid && mac_ready;
  assign w_nl_fire   = nl_valid && nl_ready;
  assign w_mac_stray = w_mac_fire && (mac_cnt_q == '0);
  assign w_nl_stray  = w_nl_fire  && (nl_cnt_q == '0);
  assign w_mac_cap   = w_mac_fire && !w_mac_stray;
  assign w_nl_cap    = w_nl_fire  && !w_nl_stray;

  assign w_mac_inc = w_push && (issue_mode == 2'd0);
  assign w_nl_inc  = w_push && (issue_mode != 2'd0);
  assign w_mac_dec = w_pop && !w_head_nl;
  assign w_nl_dec  = w_pop &&  w_head_nl;

  always_comb begin
    wr_ptr_d  = w_push ? wr_ptr_q + C_ONE : wr_ptr_q;
    rd_ptr_d  = w_pop  ? rd_ptr_q + C_ONE : rd_ptr_q;
    mac_cnt_d = mac_cnt_q;
    nl_cnt_d  = nl_cnt_q;
    if (w_mac_inc && !w_mac_dec) begin
      mac_cnt_d = mac_cnt_q + C_ONE;
    end else if (!w_mac_inc && w_mac_dec) begin
      mac_cnt_d = mac_cnt_q - C_ONE;
    end
    if (w_nl_inc && !w_nl_dec) begin
      nl_cnt_d = nl_cnt_q + C_ONE;
    end else if (!w_nl_inc && w_nl_dec) begin
      nl_cnt_d = nl_cnt_q - C_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= 2'd0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mac_cnt_q <= '0;
      nl_cnt_q  <= '0;
      stray_q   <= 1'b0;
    end else begin
      if (w_push) begin
        tag_q[wr_ptr_q[AW-1:0]] <= issue_mode;
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mac_cnt_q <= mac_cnt_d;
      nl_cnt_q  <= nl_cnt_d;
      if (w_mac_stray || w_nl_stray) begin
        stray_q <= 1'b1;
      end
    end
  end

  // Recapture wins over pop-clear so back-to-back results keep flowing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_hv_q <= 1'b0;
      mac_hd_q <= '0;
      nl_hv_q  <= 1'b0;
      nl_hd_q  <= '0;
    end else begin
      if (w_mac_cap) begin
        mac_hv_q <= 1'b1;
        mac_hd_q <= mac_res;
      end else if (w_mac_dec) begin
        mac_hv_q <= 1'b0;
      end
      if (w_nl_cap) begin
        nl_hv_q <= 1'b1;
        nl_hd_q <= nl_res;
      end else if (w_nl_dec) begin
        nl_hv_q <= 1'b0;
      end
    end
  end

  assign stray_err = stray_q;

endmodule
`default_nettype wire

// File: tb/tb_result_merge.sv
`default_nettype none
`ifndef MAC_BW
`define MAC_BW 8
`endif
// ============================================================================
//  Module      : tb_result_merge
//  Description : Scoreboard bench for result_merge ordering and flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_merge;

  localparam int LANES = 64;
  localparam int DEPTH = 4;
  localparam int BW    = `MAC_BW;
  localparam int DW    = BW * LANES;
  localparam int TMO   = 300;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic [1:0]    issue_mode = 2'd0;
  logic          issue_ready;
  logic          mac_valid = 1'b0;
  logic [DW-1:0] mac_res = '0;
  logic          mac_ready;
  logic          nl_valid = 1'b0;
  logic [DW-1:0] nl_res = '0;
  logic          nl_ready;
  logic [DW-1:0] oC;
  logic [1:0]    o_mode;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic          stray_err;

  result_merge #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_mode(issue_mode), .issue_ready(issue_ready),
    .mac_valid(mac_valid), .mac_res(mac_res), .mac_ready(mac_ready),
    .nl_valid(nl_valid), .nl_res(nl_res), .nl_ready(nl_ready),
    .oC(oC), .o_mode(o_mode), .o_valid(o_valid), .o_ready(o_ready),
    .stray_err(stray_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]    mode;
    logic [BW-1:0] base;
    logic [BW-1:0] step;
    logic [1:0]    exp_mode;
    logic [BW-1:0] exp_lane0;
  } vec_t;

  exp_t          sbq[$];
  logic [DW-1:0] mac_pend[$];
  logic [DW-1:0] nl_pend[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_popped = 0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_oC;
  logic [1:0]    prev_mode;
  exp_t          mon_e;

  function automatic logic [DW-1:0] mk(input logic [BW-1:0] base, input logic [BW-1:0] step);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      v[i*BW +: BW] = base + step * i[BW-1:0];
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: in-order scoreboard compare plus stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (!o_valid || oC !== prev_oC || o_mode !== prev_mode) begin
          n_fail++;
          $display("FAIL stall_stable: got valid=%0b mode=%0d expected held mode=%0d", o_valid, o_mode, prev_mode);
        end
      end
      if (o_valid && o_ready) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got mode=%0d with empty scoreboard", o_mode);
        end else begin
          mon_e = sbq.pop_front();
          n_popped++;
          if (oC !== mon_e.data || o_mode !== mon_e.mode) begin
            n_fail++;
            $display("FAIL result: got mode=%0d oC=%h expected mode=%0d oC=%h", o_mode, oC, mon_e.mode, mon_e.data);
          end
        end
      end
      prev_stall = o_valid && !o_ready;
      prev_oC    = oC;
      prev_mode  = o_mode;
    end
  end

  task automatic issue1(input logic [1:0] mode, input logic [DW-1:0] data, input bit pend);
    int k;
    exp_t e;
    issue_valid = 1'b1;
    issue_mode  = mode;
    k = 0;
    @(negedge clk);
    while (!issue_ready && k < TMO) begin
      @(negedge clk);
      k++;
    end
    if (k >= TMO) chk("issue_timeout", 64'd1, 64'd0);
    @(posedge clk);
    e.mode = mode;
    e.data = data;
    sbq.push_back(e);
    if (pend) begin
      if (mode == 2'd0) mac_pend.push_back(data);
      else nl_pend.push_back(data);
    end
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic deliver(input bit nl, input logic [DW-1:0] data);
    int k;
    if (nl) begin nl_valid = 1'b1; nl_res = data; end
    else begin mac_valid = 1'b1; mac_res = data; end
    k = 0;
    @(negedge clk);
    while (!(nl ? nl_ready : mac_ready) && k < TMO) begin
      @(negedge clk);
      k++;
    end
    if (k >= TMO) chk(nl ? "nl_ready_timeout" : "mac_ready_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    if (nl) nl_valid = 1'b0;
    else mac_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < TMO) begin
      tick();
      k++;
    end
    chk(name, 64'(sbq.size()), 64'd0);
    @(negedge clk);
    chk({name, "_idle"}, {63'd0, o_valid}, 64'd0);
    tick();
  endtask

  task automatic path_proc(input bit nl, input int count);
    int k;
    logic [DW-1:0] d;
    for (int n = 0; n < count; n++) begin
      k = 0;
      while ((nl ? nl_pend.size() : mac_pend.size()) == 0 && k < TMO) begin
        tick();
        k++;
      end
      if (k >= TMO) begin
        chk("pend_timeout", 64'd1, 64'd0);
        return;
      end
      d = nl ? nl_pend.pop_front() : mac_pend.pop_front();
      repeat ($urandom_range(0, 3)) tick();
      deliver(nl, d);
    end
  endtask

  vec_t dir_vec[4];
  vec_t rnd_vec[16];
  logic [DW-1:0] saved_oC;
  int n_mac, n_nl, target, k;

  initial begin
    dir_vec[0] = '{2'd0, 8'h03, 8'h00, 2'd0, 8'h03};
    dir_vec[1] = '{2'd2, 8'h0A, 8'h00, 2'd2, 8'h0A};
    dir_vec[2] = '{2'd1, 8'h70, 8'h01, 2'd1, 8'h70};
    dir_vec[3] = '{2'd0, 8'h90, 8'h03, 2'd0, 8'h90};
    n_mac = 0;
    n_nl  = 0;
    for (int i = 0; i < 16; i++) begin
      rnd_vec[i].mode      = 2'($urandom_range(0, 3));
      rnd_vec[i].base      = 8'($urandom);
      rnd_vec[i].step      = 8'($urandom_range(1, 7));
      rnd_vec[i].exp_mode  = rnd_vec[i].mode;
      rnd_vec[i].exp_lane0 = rnd_vec[i].base;
      if (rnd_vec[i].mode == 2'd0) n_mac++;
      else n_nl++;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_oC", 64'(oC), 64'd0);
    chk("rst_o_mode", {62'd0, o_mode}, 64'd0);
    chk("rst_issue_ready", {63'd0, issue_ready}, 64'd1);
    chk("rst_mac_ready", {63'd0, mac_ready}, 64'd1);
    chk("rst_nl_ready", {63'd0, nl_ready}, 64'd1);
    chk("rst_stray", {63'd0, stray_err}, 64'd0);
    tick();

    // Single MAC op with one-cycle latency
    o_ready = 1'b1;
    issue1(2'd0, mk(8'h05, 8'h00), 1'b0);
    mac_valid = 1'b1;
    mac_res   = mk(8'h05, 8'h00);
    @(negedge clk);
    chk("lat_before_capture", {63'd0, o_valid}, 64'd0);
    tick();
    mac_valid = 1'b0;
    @(negedge clk);
    chk("lat_after_capture", {63'd0, o_valid}, 64'd1);
    tick();
    @(negedge clk);
    chk("single_empty", {63'd0, o_valid}, 64'd0);
    tick();

    // Table: NL results arrive before earlier-issued MAC results
    for (int i = 0; i < 4; i++) begin
      issue1(dir_vec[i].mode, mk(dir_vec[i].exp_lane0, dir_vec[i].step), 1'b0);
      chk("tbl_mode_echo", {62'd0, dir_vec[i].exp_mode}, {62'd0, sbq[sbq.size()-1].mode});
    end
    fork
      begin
        deliver(1'b1, mk(dir_vec[1].base, dir_vec[1].step));
        @(negedge clk);
        chk("nl_waits_for_mac", {63'd0, o_valid}, 64'd0);
        deliver(1'b1, mk(dir_vec[2].base, dir_vec[2].step));
      end
      begin
        repeat (4) tick();
        deliver(1'b0, mk(dir_vec[0].base, dir_vec[0].step));
        deliver(1'b0, mk(dir_vec[3].base, dir_vec[3].step));
      end
    join
    wait_drain("tbl_drain");

    // Full FIFO: no same-cycle pop credit for issue_ready
    o_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue1(2'd0, mk(8'(i + 1), 8'h00), 1'b0);
    issue_valid = 1'b1;
    issue_mode  = 2'd0;
    @(negedge clk);
    chk("full_issue_ready", {63'd0, issue_ready}, 64'd0);
    tick();
    mac_valid = 1'b1;
    mac_res   = mk(8'h01, 8'h00);
    tick();
    mac_valid = 1'b0;
    o_ready   = 1'b1;
    @(negedge clk);
    chk("full_pop_no_credit", {63'd0, issue_ready}, 64'd0);
    tick();
    o_ready = 1'b0;
    @(negedge clk);
    chk("full_after_pop", {63'd0, issue_ready}, 64'd1);
    @(posedge clk);
    sbq.push_back('{2'd0, mk(8'h05, 8'h00)});
    #1 issue_valid = 1'b0;
    @(negedge clk);
    chk("full_again", {63'd0, issue_ready}, 64'd0);
    tick();
    o_ready = 1'b1;
    for (int i = 2; i <= 5; i++) deliver(1'b0, mk(8'(i), 8'h00));
    wait_drain("full_drain");

    // Stall with held MAC result, then back-to-back
    o_ready = 1'b0;
    issue1(2'd0, mk(8'h11, 8'h01), 1'b0);
    issue1(2'd0, mk(8'h22, 8'h01), 1'b0);
    mac_valid = 1'b1;
    mac_res   = mk(8'h11, 8'h01);
    tick();
    mac_res = mk(8'h22, 8'h01);
    @(negedge clk);
    chk("stall_mac_ready", {63'd0, mac_ready}, 64'd0);
    chk("stall_o_valid", {63'd0, o_valid}, 64'd1);
    saved_oC = oC;
    tick();
    @(negedge clk);
    chk("stall_oC_stable", {63'd0, (oC === saved_oC)}, 64'd1);
    tick();
    o_ready = 1'b1;
    @(negedge clk);
    chk("b2b_mac_ready", {63'd0, mac_ready}, 64'd1);
    tick();
    mac_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_valid", {63'd0, o_valid}, 64'd1);
    chk("b2b_second_lane0", 64'(oC[BW-1:0]), 64'h22);
    tick();
    wait_drain("b2b_drain");

    // Random traffic with random backpressure
    target = n_popped + 16;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          issue1(rnd_vec[i].mode, mk(rnd_vec[i].base, rnd_vec[i].step), 1'b1);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      path_proc(1'b0, n_mac);
      path_proc(1'b1, n_nl);
      begin
        k = 0;
        while (n_popped < target && k < 3000) begin
          tick();
          o_ready = ($urandom_range(0, 3) != 0);
          k++;
        end
        o_ready = 1'b1;
      end
    join
    chk("rnd_all_out", 64'(n_popped), 64'(target));
    chk("rnd_no_stray", {63'd0, stray_err}, 64'd0);
    wait_drain("rnd_drain");

    // Stray NL result with nothing outstanding
    deliver(1'b1, mk(8'hEE, 8'h00));
    @(negedge clk);
    chk("stray_set", {63'd0, stray_err}, 64'd1);
    chk("stray_no_valid", {63'd0, o_valid}, 64'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("stray_sticky", {63'd0, stray_err}, 64'd1);
    chk("stray_still_no_valid", {63'd0, o_valid}, 64'd0);
    tick();

    // Asynchronous reset mid-stream with three outstanding
    o_ready = 1'b0;
    issue1(2'd0, mk(8'h44, 8'h00), 1'b0);
    issue1(2'd1, mk(8'h55, 8'h00), 1'b0);
    issue1(2'd0, mk(8'h66, 8'h00), 1'b0);
    deliver(1'b0, mk(8'h44, 8'h00));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_o_valid", {63'd0, o_valid}, 64'd0);
    chk("arst_oC", 64'(oC), 64'd0);
    chk("arst_o_mode", {62'd0, o_mode}, 64'd0);
    chk("arst_issue_ready", {63'd0, issue_ready}, 64'd1);
    chk("arst_mac_ready", {63'd0, mac_ready}, 64'd1);
    chk("arst_nl_ready", {63'd0, nl_ready}, 64'd1);
    chk("arst_stray", {63'd0, stray_err}, 64'd0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    o_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", {63'd0, o_valid}, 64'd0);
      tick();
    end
    issue1(2'd3, mk(8'h5A, 8'h01), 1'b0);
    deliver(1'b1, mk(8'h5A, 8'h01));
    wait_drain("post_rst_drain");
    chk("post_rst_no_stray", {63'd0, stray_err}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
